// File: rtl/mat_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the 2x2 matrix-multiply datapath.
package mat_pkg;

  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned NUM_ELEM = 4;
  localparam int unsigned OPND_W   = 4;

  typedef logic [ELEM_W-1:0] res_elem_t;
  typedef res_elem_t [NUM_ELEM-1:0] res_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ser_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
`timescale 1ns/1ps
// Parallel-in / serial-out shift register, MSB first, zero-filled from the LSB.
module piso_shift_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift_en) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/mat_result_serializer.sv
`timescale 1ns/1ps
// Serialises the four 2x2 product elements, MSB first, C00..C11, with
// hold back-pressure and a sticky done flag.
module mat_result_serializer
  import mat_pkg::*;
#(
  parameter int unsigned ELEM_W   = mat_pkg::ELEM_W,
  parameter int unsigned NUM_ELEM = mat_pkg::NUM_ELEM
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic                          load,
  input  logic [ELEM_W*NUM_ELEM-1:0]    c_in,
  input  logic                          hold,
  output logic                          serial_out,
  output logic                          tx_valid,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_ELEM)-1:0]   elem_idx,
  output logic [$clog2(ELEM_W)-1:0]     bit_idx
);

  localparam int unsigned EIW = $clog2(NUM_ELEM);
  localparam int unsigned BIW = $clog2(ELEM_W);

  ser_state_t       state_q;
  logic             done_q;
  logic [EIW-1:0]   elem_q;
  logic [BIW-1:0]   bit_q;

  logic accept;
  logic advance;
  logic last_elem_bit;
  logic last_bit;
  logic sr_msb;

  // Load is only honoured outside SHIFT so a frame in flight cannot be clobbered.
  assign accept        = load && (state_q != SHIFT);
  assign advance       = (state_q == SHIFT) && !hold;
  assign last_elem_bit = (bit_q == BIW'(ELEM_W - 1));
  assign last_bit      = last_elem_bit && (elem_q == EIW'(NUM_ELEM - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      elem_q  <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            state_q <= SHIFT;
            done_q  <= 1'b0;
            elem_q  <= '0;
            bit_q   <= '0;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (last_elem_bit) begin
              bit_q  <= '0;
              elem_q <= elem_q + EIW'(1);
            end else begin
              bit_q  <= bit_q + BIW'(1);
            end
            if (last_bit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  piso_shift_reg #(
    .W(ELEM_W * NUM_ELEM)
  ) u_piso (
    .clk      (clk),
    .nRST     (nRST),
    .load     (accept),
    .shift_en (advance),
    .d        (c_in),
    .msb      (sr_msb)
  );

  assign busy       = (state_q == SHIFT);
  assign tx_valid   = advance;
  assign serial_out = busy && sr_msb;
  assign done       = done_q;
  assign elem_idx   = elem_q;
  assign bit_idx    = bit_q;

endmodule

// File: doc/mat_result_serializer.md
Name: mat_result_serializer

Overview:
- Output stage of the 2x2 matrix-multiply datapath.
- Captures the four 8-bit product elements C00, C01, C10, C11 on a load strobe from the multiply/accumulate stage.
- Shifts them out one bit per clock, MSB first, in element order C00→C01→C10→C11.
- Qualifies every bit with tx_valid and flags completion with a sticky done.

Parameters:
- ELEM_W, 8, width of one result element in bits.
- NUM_ELEM, 4, number of elements per result frame (2x2 matrix).

Ports:
- clk  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- load  input  1  capture request from the multiply stage; honoured only in IDLE or DONE.
- c_in  input  ELEM_W*NUM_ELEM  packed results {C00,C01,C10,C11}, C00 in the MSBs.
- hold  input  1  back-pressure; freezes shifting while high.
- serial_out  output  1  current output bit, MSB of the shift register.
- tx_valid  output  1  serial_out carries a valid frame bit this cycle.
- busy  output  1  frame in progress (state SHIFT).
- done  output  1  frame fully sent; sticky until the next accepted load.
- elem_idx  output  $clog2(NUM_ELEM)  index of the element being sent.
- bit_idx  output  $clog2(ELEM_W)  bit position within the element; 0 = MSB.

Behaviour:
- Reset (async, nRST low) forces:
  - state = IDLE;
  - shift register, counters, serial_out, tx_valid, busy, done, elem_idx, bit_idx = 0.
- Reset mid-frame aborts the frame immediately. No partial done is produced.
- States:
  - IDLE: wait for load.
  - SHIFT: transmit the frame.
  - DONE: frame complete; wait for the next load.
- Transitions:
  - IDLE/DONE, load=1 at a clock edge → SHIFT. On that edge:
    - shift register ← c_in;
    - elem_idx = 0, bit_idx = 0;
    - done ← 0.
  - SHIFT, hold=0: on each edge, shift left by 1 and increment bit_idx.
    - When bit_idx reaches ELEM_W-1, bit_idx wraps to 0 and elem_idx increments.
  - SHIFT, hold=0, last bit (elem_idx = NUM_ELEM-1 and bit_idx = ELEM_W-1) → DONE, done ← 1.
  - SHIFT, hold=1: no shift, counters frozen, stay in SHIFT.
  - DONE, load=0: remain in DONE; done stays 1.
- Outputs:
  - tx_valid = (state==SHIFT) && !hold. Registered-state-derived, with no extra pipeline stage.
  - busy = (state==SHIFT).
  - serial_out = shift register MSB; it is 0 in IDLE and DONE.
- Latency:
  - load sampled at edge N → first bit (C00[7]) valid in the cycle after edge N.
  - With hold=0 throughout: 32 consecutive tx_valid cycles; done rises at edge N+32.
- load is ignored while in SHIFT, so it cannot corrupt a frame in flight.
- c_in is sampled only on the accepting edge; later changes have no effect.
- load and hold both high in IDLE: the load is accepted, and the first cycle in SHIFT is stalled if hold is still 1.
- A consumer samples serial_out on every clk edge where tx_valid=1. Exactly ELEM_W*NUM_ELEM samples are taken per frame.

Decomposition:
- Shared package mat_pkg holds:
  - ELEM_W and NUM_ELEM constants, and the 4-bit operand width;
  - typedef res_elem_t (logic [ELEM_W-1:0]);
  - typedef res_frame_t (packed array of NUM_ELEM res_elem_t);
  - the enum ser_state_t {IDLE, SHIFT, DONE}.
- One natural sub-module, piso_shift_reg:
  - width-parameterised parallel-in/serial-out register;
  - ports: load, shift_en, d, msb.
- The FSM and counters stay in mat_result_serializer.

Test Plan:
- Basic frame:
  - Stimulus: reset; load c_in={8'd19,8'd22,8'd43,8'd50} (A={1,2,3,4} × B={5,6,7,8}), hold=0.
  - Required: 32 tx_valid bits reassemble to 19, 22, 43, 50; done=1 at load edge+32; busy=0 afterwards.
- Back-pressure:
  - Stimulus: same frame, hold=1 for 3 cycles at elem_idx=1, bit_idx=4.
  - Required: tx_valid=0 for those 3 cycles; serial_out and indices frozen; data still 19, 22, 43, 50; done at edge+35.
- Load ignored while busy:
  - Stimulus: pulse load with c_in={8'hFF,8'hFF,8'hFF,8'hFF} at bit 10 of a frame.
  - Required: the original frame is unaltered.
- Back-to-back frames:
  - Stimulus: in DONE, load {8'd0,8'd255,8'd128,8'd1}.
  - Required: done drops on the accepting edge; stream reads 0, 255, 128, 1.
- Reset mid-frame:
  - Stimulus: assert nRST low asynchronously during elem_idx=2.
  - Required: all outputs 0 immediately, state IDLE, no done; a subsequent load sends a full fresh frame.
- Boundary values:
  - Stimulus: frame of all 8'h80 and a frame of all 8'h00.
  - Required: exactly one 1-bit per element in the first frame; tx_valid still asserted for all 32 bits in both frames.
